// File: rtl/nec_ir_decoder.sv
// NEC IR receiver decoder.
// Converts the raw, active-low demodulated IR receiver output into the 8-bit
// command code for the motor direction controller. ir_code is non-zero only
// while a button is held. A valid frame starts the hold and NEC repeat codes
// refresh it. When the hold timer runs out, ir_code returns to 0x00.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   ir_rx      raw IR receiver output, asynchronous, 0 = mark, idle high
//   ir_code    decoded command while held, else 0x00
//   code_valid one-clk pulse per newly decoded frame
//   code_hold  high while the command is held
//   frame_err  one-clk pulse on any rejected frame
//
// State table:
//   IDLE        | waiting for a leader mark
//   LEAD_MARK   | inside the 9 ms leader mark
//   LEAD_SPACE  | leader space; its length selects data frame or repeat code
//   BIT_MARK    | inside a bit mark, or the stop mark once 32 bits are in
//   BIT_SPACE   | bit space; its length gives the bit value
//   REPEAT_MARK | stop mark of a repeat code
module nec_ir_decoder #(
   parameter int TICKS_PER_US     = 50,
   parameter int LEAD_MARK_US     = 9000,
   parameter int LEAD_SPACE_US    = 4500,
   parameter int REPEAT_SPACE_US  = 2250,
   parameter int BIT_MARK_US      = 560,
   parameter int ZERO_SPACE_US    = 560,
   parameter int ONE_SPACE_US     = 1690,
   parameter int FRAME_TIMEOUT_US = 20000,
   parameter int HOLD_US          = 120000,
   parameter int ADDR_CHECK       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ir_rx,
   output logic [7:0] ir_code,
   output logic       code_valid,
   output logic       code_hold,
   output logic       frame_err
);

   localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam int DW = $clog2(FRAME_TIMEOUT_US + 1);
   localparam int HW = $clog2(HOLD_US + 1);

   typedef enum logic [2:0] {
      IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REPEAT_MARK
   } state_t;

   state_t          state;
   logic            sync0, sync1, sync_prev;
   logic            rise_r, fall_r;
   logic [PW-1:0]   presc;
   logic            tick;
   logic [DW-1:0]   d;
   logic [HW-1:0]   hold_cnt;
   logic [5:0]      bitcnt;
   logic [31:0]     sr;
   logic            bit_mark_ok, frame_pass, frame_ok, repeat_ok;

   // Checks that d is within +/-25 % of the nominal duration.
   function automatic logic in_win(input logic [DW-1:0] dur, input int nom);
      int lo;
      int hi;
      lo = nom - nom / 4;
      hi = nom + nom / 4;
      return (int'(dur) >= lo) && (int'(dur) <= hi);
   endfunction

   // Two-flop synchronizer followed by a registered edge detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0     <= 1'b1;
         sync1     <= 1'b1;
         sync_prev <= 1'b1;
         rise_r    <= 1'b0;
         fall_r    <= 1'b0;
      end else begin
         sync0     <= ir_rx;
         sync1     <= sync0;
         sync_prev <= sync1;
         rise_r    <= sync1 & ~sync_prev;
         fall_r    <= ~sync1 & sync_prev;
      end
   end

   assign tick = (presc == PW'(TICKS_PER_US - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Microsecond duration since the last edge, saturating at the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d <= '0;
      end else if (rise_r || fall_r) begin
         d <= '0;
      end else if (tick && (d != DW'(FRAME_TIMEOUT_US))) begin
         d <= d + DW'(1);
      end
   end

   always_comb begin
      bit_mark_ok = in_win(d, BIT_MARK_US);
      frame_pass  = (sr[23:16] == ~sr[31:24]) &&
                    ((ADDR_CHECK == 0) || (sr[7:0] == ~sr[15:8]));
      frame_ok    = (state == BIT_MARK) && rise_r && bit_mark_ok &&
                    (bitcnt == 6'd32) && frame_pass;
      repeat_ok   = (state == REPEAT_MARK) && rise_r && bit_mark_ok;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ir_code    <= 8'h00;
         code_valid <= 1'b0;
         code_hold  <= 1'b0;
         frame_err  <= 1'b0;
         hold_cnt   <= '0;
         bitcnt     <= '0;
         sr         <= '0;
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;

         // A load or reload takes priority over expiry in the same cycle.
         if (frame_ok) begin
            ir_code    <= sr[23:16];
            code_valid <= 1'b1;
            code_hold  <= 1'b1;
            hold_cnt   <= HW'(HOLD_US);
         end else if (repeat_ok && code_hold) begin
            hold_cnt <= HW'(HOLD_US);
         end else if (code_hold && tick) begin
            if (hold_cnt == HW'(1)) begin
               hold_cnt  <= '0;
               code_hold <= 1'b0;
               ir_code   <= 8'h00;
            end else begin
               hold_cnt <= hold_cnt - HW'(1);
            end
         end

         case (state)
            IDLE: begin
               if (fall_r) state <= LEAD_MARK;
            end
            LEAD_MARK: begin
               if (rise_r) begin
                  if (in_win(d, LEAD_MARK_US)) begin
                     state <= LEAD_SPACE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            LEAD_SPACE: begin
               if (fall_r) begin
                  if (in_win(d, LEAD_SPACE_US)) begin
                     bitcnt <= '0;
                     state  <= BIT_MARK;
                  end else if (in_win(d, REPEAT_SPACE_US)) begin
                     state <= REPEAT_MARK;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            BIT_MARK: begin
               if (rise_r) begin
                  if (!bit_mark_ok) begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end else if (bitcnt == 6'd32) begin
                     if (!frame_pass) frame_err <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= BIT_SPACE;
                  end
               end
            end
            BIT_SPACE: begin
               if (fall_r) begin
                  if (in_win(d, ZERO_SPACE_US)) begin
                     sr     <= {1'b0, sr[31:1]};
                     bitcnt <= bitcnt + 6'd1;
                     state  <= BIT_MARK;
                  end else if (in_win(d, ONE_SPACE_US)) begin
                     sr     <= {1'b1, sr[31:1]};
                     bitcnt <= bitcnt + 6'd1;
                     state  <= BIT_MARK;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            REPEAT_MARK: begin
               if (rise_r) begin
                  if (!bit_mark_ok) frame_err <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // A mark or space stuck past the timeout aborts the frame.
         if ((state != IDLE) && !rise_r && !fall_r &&
             (d == DW'(FRAME_TIMEOUT_US))) begin
            frame_err <= 1'b1;
            state     <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Testbench for nec_ir_decoder. Timing is scaled by 1/20 with one tick per clock,
// so every duration below is in clock cycles.
module tb_nec_ir_decoder;

   localparam int LM   = 450;
   localparam int LS   = 225;
   localparam int RS   = 112;
   localparam int BM   = 28;
   localparam int ZS   = 28;
   localparam int OS   = 84;
   localparam int TO   = 1000;
   localparam int HOLD = 6000;

   logic       clk = 1'b0;
   logic       rst;
   logic       ir_rx;
   logic [7:0] ir_code;
   logic       code_valid;
   logic       code_hold;
   logic       frame_err;

   int checks = 0;
   int errors = 0;
   int n_valid = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   nec_ir_decoder #(
      .TICKS_PER_US(1), .LEAD_MARK_US(LM), .LEAD_SPACE_US(LS),
      .REPEAT_SPACE_US(RS), .BIT_MARK_US(BM), .ZERO_SPACE_US(ZS),
      .ONE_SPACE_US(OS), .FRAME_TIMEOUT_US(TO), .HOLD_US(HOLD), .ADDR_CHECK(0)
   ) dut (
      .clk(clk), .rst(rst), .ir_rx(ir_rx), .ir_code(ir_code),
      .code_valid(code_valid), .code_hold(code_hold), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every code_valid pulse must match the oldest expected code.
   always @(negedge clk) begin
      if (frame_err === 1'b1) n_err++;
      if (code_valid === 1'b1) begin
         n_valid++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: ir_code=%02h, no code expected", ir_code);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (ir_code !== e) begin
               errors++;
               $display("FAIL scoreboard_code: got %02h expected %02h", ir_code, e);
            end
         end
      end
   end

   task automatic level(input logic v, input int n);
      ir_rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_leader();
      level(1'b0, LM);
      level(1'b1, LS);
   endtask

   task automatic send_bits(input logic [31:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         level(1'b0, BM);
         level(1'b1, data[i] ? OS : ZS);
      end
   endtask

   task automatic send_frame(input logic [7:0] addr, input logic [7:0] cmd,
                             input logic [7:0] cinv);
      send_leader();
      send_bits({cinv, cmd, ~addr, addr}, 32);
      level(1'b0, BM);
      ir_rx = 1'b1;
   endtask

   task automatic send_repeat();
      level(1'b0, LM);
      level(1'b1, RS);
      level(1'b0, BM);
      ir_rx = 1'b1;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ir_rx = 1'b1;
      wait_clk(3);
      checks++; if (ir_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %02h expected 00", ir_code); end
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", code_valid); end
      checks++; if (code_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", code_hold); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
      rst = 1'b0;
      wait_clk(5);
   endtask

   task automatic test_single_frame();
      exp_q.push_back(8'h02);
      send_frame(8'h00, 8'h02, 8'hFD);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         checks++;
         if (code_valid !== 1'b0) begin errors++; $display("FAIL latency_early: cycle %0d valid=%b expected 0", i, code_valid); end
      end
      @(negedge clk);
      checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL latency_4clk: valid=%b expected 1", code_valid); end
      checks++; if (ir_code !== 8'h02) begin errors++; $display("FAIL frame1_code: got %02h expected 02", ir_code); end
      checks++; if (code_hold !== 1'b1) begin errors++; $display("FAIL frame1_hold: got %b expected 1", code_hold); end
      @(negedge clk);
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: valid=%b expected 0", code_valid); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frame1_seen: pending=%0d expected 0", exp_q.size()); end
      wait_clk(HOLD - 2);
      checks++; if (code_hold !== 1'b1 || ir_code !== 8'h02) begin errors++; $display("FAIL hold_before_expiry: hold=%b code=%02h expected 1/02", code_hold, ir_code); end
      @(negedge clk);
      checks++; if (code_hold !== 1'b0 || ir_code !== 8'h00) begin errors++; $display("FAIL hold_expiry: hold=%b code=%02h expected 0/00", code_hold, ir_code); end
   endtask

   task automatic test_repeat();
      int v0;
      v0 = n_valid;
      exp_q.push_back(8'h08);
      send_frame(8'h00, 8'h08, 8'hF7);
      level(1'b1, 2000);
      for (int r = 0; r < 3; r++) begin
         if (r != 0) level(1'b1, 4800);
         send_repeat();
         if (r != 2) begin
            wait_clk(10);
            checks++;
            if (ir_code !== 8'h08 || code_hold !== 1'b1) begin errors++; $display("FAIL repeat_held_%0d: code=%02h hold=%b expected 08/1", r, ir_code, code_hold); end
         end
      end
      wait_clk(4);
      checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL repeat_valid_count: got %0d expected 1", n_valid - v0); end
      wait_clk(HOLD - 1);
      checks++; if (code_hold !== 1'b1 || ir_code !== 8'h08) begin errors++; $display("FAIL repeat_before_expiry: hold=%b code=%02h expected 1/08", code_hold, ir_code); end
      @(negedge clk);
      checks++; if (code_hold !== 1'b0 || ir_code !== 8'h00) begin errors++; $display("FAIL repeat_expiry: hold=%b code=%02h expected 0/00", code_hold, ir_code); end
   endtask

   task automatic test_bad_complement();
      int e0, v0;
      e0 = n_err;
      v0 = n_valid;
      send_frame(8'h00, 8'h20, 8'hDE);
      wait_clk(8);
      checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL badcmp_err: pulses=%0d expected 1", n_err - e0); end
      checks++; if (n_valid != v0) begin errors++; $display("FAIL badcmp_valid: pulses=%0d expected 0", n_valid - v0); end
      checks++; if (ir_code !== 8'h00) begin errors++; $display("FAIL badcmp_code: got %02h expected 00", ir_code); end
   endtask

   task automatic test_short_leader();
      int e0;
      e0 = n_err;
      level(1'b0, 300);
      level(1'b1, 500);
      checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL short_leader_err: pulses=%0d expected 1", n_err - e0); end
      exp_q.push_back(8'h80);
      send_frame(8'h00, 8'h80, 8'h7F);
      wait_clk(8);
      checks++; if (ir_code !== 8'h80 || code_hold !== 1'b1) begin errors++; $display("FAIL short_leader_code: code=%02h hold=%b expected 80/1", ir_code, code_hold); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL short_leader_seen: pending=%0d expected 0", exp_q.size()); end
      wait_clk(HOLD + 100);
      checks++; if (code_hold !== 1'b0 || ir_code !== 8'h00) begin errors++; $display("FAIL short_leader_expiry: hold=%b code=%02h expected 0/00", code_hold, ir_code); end
   endtask

   task automatic test_timeout();
      int e0, v0;
      send_leader();
      send_bits(32'h0000_0155, 10);
      ir_rx = 1'b0;
      wait_clk(TO + 4);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL timeout_early: err=%b expected 0", frame_err); end
      @(negedge clk);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL timeout_at_limit: err=%b expected 1", frame_err); end
      wait_clk(1250 - TO - 5);
      e0 = n_err;
      v0 = n_valid;
      level(1'b1, 300);
      send_repeat();
      wait_clk(20);
      checks++; if (n_err != e0) begin errors++; $display("FAIL lone_repeat_err: pulses=%0d expected 0", n_err - e0); end
      checks++; if (n_valid != v0) begin errors++; $display("FAIL lone_repeat_valid: pulses=%0d expected 0", n_valid - v0); end
      checks++; if (ir_code !== 8'h00 || code_hold !== 1'b0) begin errors++; $display("FAIL lone_repeat_outputs: code=%02h hold=%b expected 00/0", ir_code, code_hold); end
   endtask

   task automatic test_reset_mid_frame();
      exp_q.push_back(8'h20);
      send_frame(8'h00, 8'h20, 8'hDF);
      wait_clk(8);
      checks++; if (ir_code !== 8'h20 || code_hold !== 1'b1) begin errors++; $display("FAIL pre_reset_hold: code=%02h hold=%b expected 20/1", ir_code, code_hold); end
      send_leader();
      send_bits(32'hDF20_FF00, 16);
      rst = 1'b1;
      #1;
      checks++; if (ir_code !== 8'h00 || code_hold !== 1'b0) begin errors++; $display("FAIL async_reset: code=%02h hold=%b expected 00/0", ir_code, code_hold); end
      ir_rx = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      level(1'b1, 50);
      exp_q.push_back(8'h20);
      send_frame(8'h00, 8'h20, 8'hDF);
      wait_clk(8);
      checks++; if (ir_code !== 8'h20 || code_hold !== 1'b1) begin errors++; $display("FAIL post_reset_frame: code=%02h hold=%b expected 20/1", ir_code, code_hold); end
   endtask

   initial begin
      rst = 1'b1;
      ir_rx = 1'b1;
      test_reset();
      test_single_frame();
      test_repeat();
      test_bad_complement();
      test_short_leader();
      test_timeout();
      test_reset_mid_frame();
      wait_clk(2);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nec_ir_decoder.md
Name: nec_ir_decoder

Overview:
Decodes the raw demodulated output of the IR receiver module (NEC protocol) into the 8-bit command code that drives the motor direction controller.
- It sits directly upstream of the motor controller and feeds its 8-bit IR command input.
- `ir_code` is non-zero only while a button is considered held: a valid frame, refreshed by NEC repeat codes.
- `ir_code` returns to 0x00 when the hold times out.

Parameters:
- TICKS_PER_US, 50, clk cycles per microsecond (50 MHz system clock).
- LEAD_MARK_US, 9000, nominal leader mark.
- LEAD_SPACE_US, 4500, nominal leader space (data frame).
- REPEAT_SPACE_US, 2250, nominal leader space (repeat code).
- BIT_MARK_US, 560, nominal bit/stop mark.
- ZERO_SPACE_US, 560, nominal space for logic 0.
- ONE_SPACE_US, 1690, nominal space for logic 1.
- FRAME_TIMEOUT_US, 20000, maximum duration of any mark/space inside a frame.
- HOLD_US, 120000, hold time after the last valid frame or repeat.
- ADDR_CHECK, 0, 1 = also require address byte == ~inverted-address byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ir_rx  in  1  raw IR receiver output, asynchronous; active-low (0 = mark), idle high
- ir_code  out  8  decoded command while held, else 0x00
- code_valid  out  1  one-clk pulse per newly decoded frame
- code_hold  out  1  high while the command is held
- frame_err  out  1  one-clk pulse on any rejected frame

Behaviour:
- Reset (async, rst=1): state IDLE; ir_code=0x00; code_valid=0; code_hold=0; frame_err=0; all counters 0; sync flops=1.
- Input conditioning: 2-flop synchronizer, then edge detect.
  - Mark start = falling edge of the synced signal.
  - Mark end = rising edge of the synced signal.
- Microsecond tick: prescaler counts 0..TICKS_PER_US-1.
- Duration counter d (us):
  - Cleared on every edge.
  - Incremented on each tick.
  - Saturates at FRAME_TIMEOUT_US.
- Window test: d is in window(N) iff N - N/4 <= d <= N + N/4 (integer division).
- FSM (edges evaluated using d before clearing):
  - IDLE: on mark start -> LEAD_MARK.
  - LEAD_MARK: on mark end, window(LEAD_MARK_US) -> LEAD_SPACE; else error.
  - LEAD_SPACE: on mark start:
    - window(LEAD_SPACE_US) -> BIT_MARK, bitcnt=0.
    - window(REPEAT_SPACE_US) -> REPEAT_MARK.
    - Otherwise error.
  - BIT_MARK: on mark end, window(BIT_MARK_US) required, else error.
    - bitcnt==32 -> frame check, then IDLE.
    - Otherwise -> BIT_SPACE.
  - BIT_SPACE: on mark start:
    - window(ZERO_SPACE_US) shifts in 0; window(ONE_SPACE_US) shifts in 1; otherwise error.
    - bitcnt++ -> BIT_MARK.
  - REPEAT_MARK: on mark end, window(BIT_MARK_US) -> repeat accepted, IDLE; else error.
  - Any non-IDLE state with d == FRAME_TIMEOUT_US -> error.
  - Error: frame_err pulses 1 clk, -> IDLE, partial data discarded.
- Bit order is LSB first.
  - Shift register is 32 bits, right-shift, new bit enters bit 31.
  - After 32 bits: [7:0]=addr, [15:8]=~addr, [23:16]=cmd, [31:24]=~cmd.
- Frame check:
  - Pass requires cmd == ~[31:24], plus addr check if ADDR_CHECK=1.
  - On pass: ir_code<=cmd; code_valid pulses 1 clk; code_hold<=1; hold timer <= HOLD_US.
  - On fail: frame_err pulse.
- Repeat accepted with code_hold=1: hold timer reloads HOLD_US; ir_code unchanged; no code_valid.
- Repeat accepted with code_hold=0: ignored, no error.
- Hold timer:
  - Decrements per us tick while code_hold=1.
  - On reaching 0: code_hold<=0 and ir_code<=0x00 in the same clk.
  - Invariant: ir_code==0x00 whenever code_hold==0.
- Simultaneous events:
  - Reload and expiry on the same clk: reload wins.
  - New valid frame while holding: replaces ir_code and pulses code_valid.
  - Errors never clear an active hold.
- Latency: code_valid / ir_code update occurs exactly 4 clk after the first clk that samples the final ir_rx rising edge (2 sync + edge detect + FSM register).
- Reset mid-frame: immediate return to reset values; the next full frame decodes normally.

Test Plan:
- Sim parameters: TICKS_PER_US=1 is allowed for sim speed; all us values below are in ticks.
1. Frame addr 0x00, cmd 0x02 (bytes 00 FF 02 FD) -> code_valid one pulse 4 clk after final rising edge; ir_code=0x02; code_hold=1. No further input -> ir_code=0x00 and code_hold=0 at 120000 us after the pulse.
2. Frame cmd 0x08, then 3 repeat codes at 108 ms spacing -> ir_code stays 0x08 throughout; code_valid pulses exactly once; ir_code drops to 0x00 120000 us after the last repeat.
3. Frame with bytes 00 FF 20 DE (bad complement) -> frame_err one pulse; no code_valid; ir_code unchanged (0x00).
4. Leader mark 6000 us, then valid frame cmd 0x80 -> frame_err on the short leader; ir_code=0x80 after the second frame.
5. ir_rx held low 25 ms after bit 10 -> frame_err at d=20000; a following lone repeat code with code_hold=0 -> no outputs change.
6. rst asserted at bit 16 of a frame, while holding 0x20 -> ir_code=0x00 and code_hold=0 asynchronously. After release, a fresh frame cmd 0x20 -> ir_code=0x20.
